// File: rtl/pwm_capture_if.sv
// Request/result bundle between firmware-facing logic and the pwm_capture self-test decoder.
interface pwm_capture_if #(
  parameter int SEL_W = 8
);
  logic             START;
  logic [SEL_W-1:0] CH_SEL;
  logic             BUSY;
  logic             DOUT_VALID;
  logic [8:0]       PULSE_WIDTH;
  logic [7:0]       PHASE;
  logic [1:0]       STATUS;

  modport master (
    output START, CH_SEL,
    input  BUSY, DOUT_VALID, PULSE_WIDTH, PHASE, STATUS
  );

  modport slave (
    input  START, CH_SEL,
    output BUSY, DOUT_VALID, PULSE_WIDTH, PHASE, STATUS
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures pulse width and phase of one PWM channel over one 512-tick carrier period.
// Optional macro PWM_CAPTURE_CONTINUOUS_EN: back-to-back measurements while START stays high.
module pwm_capture #(
  parameter int DEPTH = 249,
  parameter int SEL_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [8:0]       TIME_CNT,
  input  logic [DEPTH-1:0] PWM_IN,
  pwm_capture_if.slave     bus
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEASURE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_lvl;
  logic [8:0]       r_ts;
  logic             r_prev;
  logic [8:0]       r_rise;
  logic [8:0]       r_fall;
  logic [1:0]       r_nrise;
  logic [1:0]       r_nfall;
  logic [8:0]       r_cnt;
  logic             r_inv;
  logic             r_busy;
  logic             r_valid;
  logic [8:0]       r_pw;
  logic [7:0]       r_phase;
  logic [1:0]       r_status;

  logic             w_lvl;
  logic             w_oor;
  logic [8:0]       w_w;

  // Out-of-range selects never reach MEASURE, but keep the mux read defined anyway.
  assign w_lvl = (32'(r_sel) < DEPTH) ? PWM_IN[r_sel] : 1'b0;
  assign w_oor = (32'(bus.CH_SEL) >= DEPTH);
  assign w_w   = r_fall - r_rise;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_lvl    <= 1'b0;
      r_ts     <= '0;
      r_prev   <= 1'b0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_nrise  <= '0;
      r_nfall  <= '0;
      r_cnt    <= '0;
      r_inv    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_pw     <= '0;
      r_phase  <= '0;
      r_status <= '0;
    end else begin
      r_lvl   <= w_lvl;
      r_ts    <= TIME_CNT;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_sel   <= bus.CH_SEL;
            r_busy  <= 1'b1;
            r_inv   <= w_oor;
            r_state <= w_oor ? S_CALC : S_ARM;
          end
        end
        S_ARM: begin
          if (r_ts == 9'd511) begin
            r_prev  <= r_lvl;
            r_nrise <= '0;
            r_nfall <= '0;
            r_cnt   <= '0;
            r_state <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (r_lvl && !r_prev) begin
            r_rise <= r_ts;
            if (r_nrise != 2'd3) r_nrise <= r_nrise + 2'd1;
          end
          if (!r_lvl && r_prev) begin
            r_fall <= r_ts;
            if (r_nfall != 2'd3) r_nfall <= r_nfall + 2'd1;
          end
          r_prev <= r_lvl;
          r_cnt  <= r_cnt + 9'd1;
          // 512 samples; in one-shot mode this coincides with the ts=511 sample.
          if (r_cnt == 9'd511) r_state <= S_CALC;
        end
        S_CALC: begin
          if (r_inv) begin
            r_pw <= '0; r_phase <= '0; r_status <= 2'd3;
          end else if (r_nrise == 2'd1 && r_nfall == 2'd1) begin
            r_pw     <= w_w;
            r_phase  <= 8'((r_rise + (w_w >> 1)) >> 1);
            r_status <= 2'd0;
          end else if (r_nrise == 2'd0 && r_nfall == 2'd0) begin
            r_pw     <= r_prev ? 9'd511 : 9'd0;
            r_phase  <= '0;
            r_status <= r_prev ? 2'd2 : 2'd1;
          end else begin
            r_pw <= '0; r_phase <= '0; r_status <= 2'd3;
          end
          r_valid <= 1'b1;
`ifdef PWM_CAPTURE_CONTINUOUS_EN
          r_busy  <= bus.START && !r_inv;
`else
          r_busy  <= 1'b0;
`endif
          r_state <= S_DONE;
        end
        S_DONE: begin
`ifdef PWM_CAPTURE_CONTINUOUS_EN
          // ts=511 was already consumed, so re-enter MEASURE without re-arming.
          if (r_busy) begin
            r_nrise <= '0;
            r_nfall <= '0;
            r_cnt   <= '0;
            r_state <= S_MEASURE;
          end else begin
            r_state <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY        = r_busy;
  assign bus.DOUT_VALID  = r_valid;
  assign bus.PULSE_WIDTH = r_pw;
  assign bus.PHASE       = r_phase;
  assign bus.STATUS      = r_status;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed, table-driven bench for pwm_capture with hand-computed expected results.
module tb_pwm_capture;
  localparam int DEPTH = 249;
  localparam int SEL_W = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [8:0]       tcnt  = '0;
  logic [DEPTH-1:0] pwm;
  logic             w_l;

  int sig_ch   = 0;
  int sig_mode = 0;
  int sig_lo   = 0;
  int sig_hi   = 0;

  int checks   = 0;
  int failures = 0;

  pwm_capture_if #(.SEL_W(SEL_W)) bus ();

  pwm_capture #(.DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .TIME_CNT (tcnt),
    .PWM_IN   (pwm),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 9'd1;

  function automatic logic in_rng(input int t, input int lo, input int hi);
    if (lo <= hi) return (t >= lo) && (t <= hi);
    return (t >= lo) || (t <= hi);
  endfunction

  // mode 0: low, 1: high, 2: one pulse lo..hi (may wrap), 3: two 10-tick pulses at lo and hi
  function automatic logic lvl_at(input int t, input int mode, input int lo, input int hi);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return in_rng(t, lo, hi);
      default: return in_rng(t, lo, lo + 9) || in_rng(t, hi, hi + 9);
    endcase
  endfunction

  assign w_l = lvl_at(int'(tcnt), sig_mode, sig_lo, sig_hi);

  // Non-selected channels carry the complement so a wrong channel mux shows up.
  always_comb begin
    pwm = '0;
    for (int i = 0; i < DEPTH; i++) pwm[i] = (i == sig_ch) ? w_l : ~w_l;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_sig(input int ch, input int mode, input int lo, input int hi);
    sig_ch = ch; sig_mode = mode; sig_lo = lo; sig_hi = hi;
  endtask

  task automatic wait_valid(input int limit, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!bus.DOUT_VALID && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    got = bus.DOUT_VALID;
  endtask

  task automatic run_meas(input int ch, output int lat, output bit got);
    @(negedge clk);
    bus.START  = 1'b1;
    bus.CH_SEL = 8'(ch);
    @(negedge clk);
    bus.START  = 1'b0;
    lat = 1;
    chk("busy_after_start", int'(bus.BUSY), 1);
    if (!bus.DOUT_VALID) begin
      int more;
      wait_valid(1100, more, got);
      lat += more;
    end else begin
      got = 1'b1;
    end
  endtask

  typedef struct {
    int ch;
    int mode;
    int lo;
    int hi;
    int pw;
    int ph;
    int st;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  lat;
    bit  got;
    int  n;
    bus.START  = 1'b0;
    bus.CH_SEL = '0;

    vecs[0] = '{ch:5,   mode:2, lo:100, hi:199, pw:100, ph:75,  st:0};
    vecs[1] = '{ch:0,   mode:2, lo:500, hi:19,  pw:32,  ph:2,   st:0};
    vecs[2] = '{ch:248, mode:0, lo:0,   hi:0,   pw:0,   ph:0,   st:1};
    vecs[3] = '{ch:248, mode:1, lo:0,   hi:0,   pw:511, ph:0,   st:2};
    vecs[4] = '{ch:249, mode:2, lo:100, hi:199, pw:0,   ph:0,   st:3};
    vecs[5] = '{ch:7,   mode:3, lo:10,  hi:300, pw:0,   ph:0,   st:3};
    vecs[6] = '{ch:100, mode:2, lo:0,   hi:255, pw:256, ph:64,  st:0};
    vecs[7] = '{ch:3,   mode:2, lo:400, hi:510, pw:111, ph:227, st:0};

    repeat (3) @(negedge clk);
    chk("reset_busy",   int'(bus.BUSY), 0);
    chk("reset_valid",  int'(bus.DOUT_VALID), 0);
    chk("reset_pw",     int'(bus.PULSE_WIDTH), 0);
    chk("reset_phase",  int'(bus.PHASE), 0);
    chk("reset_status", int'(bus.STATUS), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      set_sig(vecs[i].ch, vecs[i].mode, vecs[i].lo, vecs[i].hi);
      run_meas(vecs[i].ch, lat, got);
      chk($sformatf("v%0d_valid", i), int'(got), 1);
      chk($sformatf("v%0d_pw", i), int'(bus.PULSE_WIDTH), vecs[i].pw);
      chk($sformatf("v%0d_phase", i), int'(bus.PHASE), vecs[i].ph);
      chk($sformatf("v%0d_status", i), int'(bus.STATUS), vecs[i].st);
      chk($sformatf("v%0d_busy_at_valid", i), int'(bus.BUSY), 0);
      if (vecs[i].ch >= DEPTH) chk($sformatf("v%0d_latency", i), lat, 2);
      else chk($sformatf("v%0d_latency_bound", i), int'(lat <= 1027), 1);
      @(negedge clk);
      chk($sformatf("v%0d_valid_one_cycle", i), int'(bus.DOUT_VALID), 0);
      chk($sformatf("v%0d_hold_pw", i), int'(bus.PULSE_WIDTH), vecs[i].pw);
    end

    // START with another channel during BUSY must not disturb the running request.
    set_sig(5, 2, 100, 199);
    @(negedge clk);
    bus.START = 1'b1; bus.CH_SEL = 8'd5;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (30) @(negedge clk);
    bus.START = 1'b1; bus.CH_SEL = 8'd0;
    @(negedge clk);
    bus.START = 1'b0; bus.CH_SEL = 8'd0;
    wait_valid(1100, lat, got);
    chk("ign_valid",  int'(got), 1);
    chk("ign_pw",     int'(bus.PULSE_WIDTH), 100);
    chk("ign_phase",  int'(bus.PHASE), 75);
    chk("ign_status", int'(bus.STATUS), 0);
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (bus.DOUT_VALID || bus.BUSY) n++;
    end
    chk("ign_no_second_result", n, 0);

    // Reset in the middle of MEASURE.
    lat = 0;
    while (tcnt != 9'd200 && lat < 600) begin @(negedge clk); lat++; end
    bus.START = 1'b1; bus.CH_SEL = 8'd5;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (400) @(negedge clk);
    chk("abort_busy_before", int'(bus.BUSY), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   int'(bus.BUSY), 0);
    chk("abort_valid",  int'(bus.DOUT_VALID), 0);
    chk("abort_pw",     int'(bus.PULSE_WIDTH), 0);
    chk("abort_phase",  int'(bus.PHASE), 0);
    chk("abort_status", int'(bus.STATUS), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (bus.DOUT_VALID) n++;
    end
    chk("abort_no_strobe", n, 0);
    run_meas(5, lat, got);
    chk("fresh_valid",  int'(got), 1);
    chk("fresh_pw",     int'(bus.PULSE_WIDTH), 100);
    chk("fresh_phase",  int'(bus.PHASE), 75);
    chk("fresh_status", int'(bus.STATUS), 0);

`ifdef PWM_CAPTURE_CONTINUOUS_EN
    // START held: width 100 then 200, strobes 514 cycles apart, then drop START.
    repeat (3) @(negedge clk);
    set_sig(5, 2, 100, 199);
    bus.START = 1'b1; bus.CH_SEL = 8'd5;
    @(negedge clk);
    wait_valid(1100, lat, got);
    chk("cont_first_valid", int'(got), 1);
    chk("cont_first_pw",    int'(bus.PULSE_WIDTH), 100);
    chk("cont_first_busy",  int'(bus.BUSY), 1);
    set_sig(5, 2, 100, 299);
    @(negedge clk);
    wait_valid(1100, lat, got);
    chk("cont_second_valid", int'(got), 1);
    chk("cont_gap",          lat + 1, 514);
    chk("cont_second_pw",    int'(bus.PULSE_WIDTH), 200);
    bus.START = 1'b0;
    @(negedge clk);
    wait_valid(1100, lat, got);
    chk("cont_last_valid", int'(got), 1);
    chk("cont_last_busy",  int'(bus.BUSY), 0);
    repeat (2) @(negedge clk);
    chk("cont_idle_busy", int'(bus.BUSY), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
